// File: rtl/serial_subtractor_nb.sv
// ---------------------------------------------------------------------------
// serial_subtractor_nb : bit-serial a - b - bin, LSB first, start/done handshake
// Optional: SERIAL_SUB_OVERFLOW_EN adds the two's-complement overflow flag ovf.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_subtractor_nb #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam logic [1:0]       S_IDLE  = 2'd0;
  localparam logic [1:0]       S_SHIFT = 2'd1;
  localparam logic [1:0]       S_DONE  = 2'd2;
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-2:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_br_nxt;
  logic [WIDTH-1:0] w_res_full;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_SHIFT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    w_accept = 1'b0;
    w_shift  = 1'b0;
    case (r_state)
      S_IDLE:  w_accept = start;
      S_SHIFT: begin
        busy    = 1'b1;
        w_shift = 1'b1;
      end
      S_DONE:  begin
        done     = 1'b1;
        w_accept = start;
      end
      default: ;
    endcase
  end

  assign w_last = w_shift && (r_cnt == C_LAST);

  // Full-subtractor cell
  assign w_x        = r_ra[0];
  assign w_y        = r_rb[0];
  assign w_d        = w_x ^ w_y ^ r_br;
  assign w_br_nxt   = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_res_full = {w_d, r_res};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ra   <= '0;
      r_rb   <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_res  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_ra  <= a;
      r_rb  <= b;
      r_br  <= bin;
      r_cnt <= '0;
      r_res <= '0;
    end else if (w_shift) begin
      r_ra  <= {1'b0, r_ra[WIDTH-1:1]};
      r_rb  <= {1'b0, r_rb[WIDTH-1:1]};
      r_br  <= w_br_nxt;
      r_cnt <= r_cnt + 1'b1;
      r_res <= w_res_full[WIDTH-1:1];
      // Results are published only on the final bit so no partial value is ever visible
      if (w_last) begin
        r_diff <= w_res_full;
        r_bout <= w_br_nxt;
      end
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;

`ifdef SERIAL_SUB_OVERFLOW_EN
  // Operand sign bits are shifted out during the run, so keep a copy for the flag
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (w_last) begin
      r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor_nb.sv
// Directed bench for serial_subtractor_nb (WIDTH=4) with a result scoreboard.
`default_nettype none

module tb_serial_subtractor_nb;

  logic       clock;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] q_exp[$];

  serial_subtractor_nb #(.WIDTH(4), .CNT_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .ovf   (ovf),
`endif
    .bout  (bout)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, bout, diff} from plain 5-bit arithmetic
  function automatic logic [5:0] model(input logic [3:0] fa, input logic [3:0] fb, input logic fbin);
    logic [4:0] t;
    logic       o;
    t = {1'b0, fa} - {1'b0, fb} - {4'b0, fbin};
    o = (fa[3] != fb[3]) && (t[3] != fa[3]);
    return {o, t[4], t[3:0]};
  endfunction

  // Drive a request at a negedge; returns one negedge later with start dropped
  task automatic issue(input logic [3:0] ia, input logic [3:0] ib, input logic ibin, input bit push);
    a     = ia;
    b     = ib;
    bin   = ibin;
    start = 1'b1;
    if (push) q_exp.push_back(model(ia, ib, ibin));
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      if (done === 1'b1) break;
    end
    if (k == 20) chk("done_timeout", {31'b0, done}, 32'd1);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (q_exp.size() == 0) begin
        chk("spurious_done", {31'b0, done}, 32'd0);
      end else begin
        logic [5:0] e;
        e = q_exp.pop_front();
        chk("diff", {28'b0, diff}, {28'b0, e[3:0]});
        chk("bout", {31'b0, bout}, {31'b0, e[4]});
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("ovf", {31'b0, ovf}, {31'b0, e[5]});
`endif
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_diff", {28'b0, diff}, 32'd0);
    chk("rst_bout", {31'b0, bout}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Latency: four busy cycles then done
    issue(4'b1101, 4'b1000, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("lat_busy", {31'b0, busy}, 32'd1);
      chk("lat_notdone", {31'b0, done}, 32'd0);
      @(negedge clock);
    end
    chk("lat_done", {31'b0, done}, 32'd1);
    chk("lat_idle_busy", {31'b0, busy}, 32'd0);

    // Back-to-back request issued in the done cycle
    issue(4'b1010, 4'b1001, 1'b0, 1'b1);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    chk("b2b_notdone", {31'b0, done}, 32'd0);
    wait_done();
    @(negedge clock);
    chk("pulse_done", {31'b0, done}, 32'd0);
    chk("pulse_busy", {31'b0, busy}, 32'd0);

    issue(4'b1000, 4'b1101, 1'b0, 1'b1);
    wait_done();
    @(negedge clock);
    issue(4'b0000, 4'b0000, 1'b1, 1'b1);
    wait_done();
    @(negedge clock);
    issue(4'b1111, 4'b1111, 1'b0, 1'b1);
    wait_done();
    @(negedge clock);

    // Start re-pulsed while busy must be ignored
    issue(4'b0111, 4'b1000, 1'b0, 1'b1);
    a     = 4'b0001;
    b     = 4'b0001;
    bin   = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("ign_busy", {31'b0, busy}, 32'd1);
    @(negedge clock);
    chk("ign_done", {31'b0, done}, 32'd1);
    @(negedge clock);
    chk("ign_after", {31'b0, done}, 32'd0);
    @(negedge clock);

    // Reset on the second busy cycle aborts with no done
    issue(4'b1111, 4'b0001, 1'b0, 1'b0);
    @(negedge clock);
    chk("abort_pre_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_diff", {28'b0, diff}, 32'd0);
    chk("abort_bout", {31'b0, bout}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    chk("abort_idle", {31'b0, busy}, 32'd0);
    chk("sb_empty", q_exp.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
